// File: rtl/layer_fb_arbiter.sv
// rtl/layer_fb_arbiter.sv - round-robin framebuffer write arbiter between pixel draws and layer clears
// Optional LAYER_FB_LOCK_EN: blocks draws to the layer currently being cleared.
module layer_fb_arbiter #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int COLOR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               draw_req,
    input  logic [9:0]         draw_x,
    input  logic [8:0]         draw_y,
    input  logic [2:0]         draw_layer,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               draw_ack,
    input  logic               clear_start,
    input  logic [2:0]         clear_layer,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               fb_we,
    output logic [9:0]         fb_x,
    output logic [8:0]         fb_y,
    output logic [2:0]         fb_layer,
    output logic [COLOR_W-1:0] fb_data
);

    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_nxt;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [2:0] clr_layer;
    logic       last_grant_clear;
    logic       draw_blocked;
    logic       draw_elig, clear_elig;
    logic       grant_draw, grant_clear;
    logic       clear_last;

`ifdef LAYER_FB_LOCK_EN
    assign draw_blocked = (state == CLEAR) && (draw_layer == clr_layer);
`else
    assign draw_blocked = 1'b0;
`endif

    assign draw_elig   = draw_req && !reset && !draw_blocked;
    assign clear_elig  = (state == CLEAR);
    // On contention the requester that did not win last time is served.
    assign grant_draw  = draw_elig && (!clear_elig || last_grant_clear);
    assign grant_clear = clear_elig && (!draw_elig || !last_grant_clear);
    assign draw_ack    = grant_draw;
    assign clear_last  = (cx == X_LAST) && (cy == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (grant_clear && clear_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx               <= '0;
            cy               <= '0;
            clr_layer        <= '0;
            last_grant_clear <= 1'b1;
            clear_done       <= 1'b0;
            fb_we            <= 1'b0;
            fb_x             <= '0;
            fb_y             <= '0;
            fb_layer         <= '0;
            fb_data          <= '0;
        end else begin
            clear_done <= grant_clear && clear_last;
            fb_we      <= grant_draw || grant_clear;
            if (grant_draw) begin
                fb_x             <= draw_x;
                fb_y             <= draw_y;
                fb_layer         <= draw_layer;
                fb_data          <= draw_color;
                last_grant_clear <= 1'b0;
            end else if (grant_clear) begin
                fb_x             <= cx;
                fb_y             <= cy;
                fb_layer         <= clr_layer;
                fb_data          <= '0;
                last_grant_clear <= 1'b1;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= clear_last ? 9'd0 : cy + 9'd1;
                end else begin
                    cx <= cx + 10'd1;
                end
            end
            // Only accepted in IDLE, where no clear grant can move the counters.
            if (state == IDLE && clear_start) begin
                clr_layer <= clear_layer;
                cx        <= '0;
                cy        <= '0;
            end
        end
    end

endmodule

// File: doc/layer_fb_arbiter.md
LAYER_FB_ARBITER -- requirements
Module: layer_fb_arbiter

Interface
REQ-001 The block SHALL have parameters, one per line:
- H_PIXELS, default 640, pixel columns per layer.
- V_PIXELS, default 480, pixel rows per layer.
- COLOR_W, default 8, pixel color width.

REQ-002 The block SHALL have ports, one per line:
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset.
- draw_req  in  1  draw requester has a pixel pending; held with stable draw_* data until draw_ack.
- draw_x  in  10  pixel column.
- draw_y  in  9  pixel row.
- draw_layer  in  3  target layer.
- draw_color  in  COLOR_W  pixel value.
- draw_ack  out  1  combinational; draw pixel granted this cycle.
- clear_start  in  1  one-cycle request to clear a layer.
- clear_layer  in  3  layer to clear; sampled with clear_start.
- clear_busy  out  1  clear sequence in progress.
- clear_done  out  1  one-cycle pulse at clear completion.
- fb_we  out  1  registered framebuffer write enable.
- fb_x  out  10  registered write column.
- fb_y  out  9  registered write row.
- fb_layer  out  3  registered write layer.
- fb_data  out  COLOR_W  registered write data.

Function
REQ-003 FSM states SHALL be IDLE and CLEAR; the arbiter SHALL be active in both states.
REQ-004 In IDLE, clear_start SHALL latch clear_layer, zero the clear counters (cx=0, cy=0) and enter CLEAR next cycle; clear_busy SHALL be high from that next cycle.
REQ-005 clear_start while in CLEAR SHALL be ignored; the latched layer and counters are unchanged.
REQ-006 A request is eligible per cycle: draw when draw_req=1; clear when state=CLEAR.
REQ-007 With one eligible request, it SHALL be granted; with both eligible, the one not granted most recently SHALL be granted (round-robin; last_grant resets to "clear", so draw wins the first contention).
REQ-008 draw_ack SHALL equal the draw grant in the same cycle; at most one grant per cycle.
REQ-009 A grant in cycle t SHALL produce fb_we=1 in cycle t+1 with the granted x, y, layer and data (1-cycle latency); with no grant, fb_we=0 in t+1 and fb_x/fb_y/fb_layer/fb_data hold their prior values.
REQ-010 A clear grant SHALL write data 0 at (cx, cy, latched layer), then advance cx; when cx=H_PIXELS-1, cx wraps to 0 and cy increments.
REQ-011 The clear grant at (H_PIXELS-1, V_PIXELS-1) SHALL return state to IDLE; clear_done=1 and clear_busy=0 in the next cycle, coinciding with fb_we for that final pixel.
REQ-012 clear_start arriving in the same cycle as clear_done SHALL be accepted (state is IDLE).
REQ-013 A clear SHALL complete in exactly H_PIXELS*V_PIXELS clear grants; with continuous draw_req it SHALL take at most 2*H_PIXELS*V_PIXELS cycles.
REQ-014 Out-of-range draw_x/draw_y SHALL be passed through unchecked.

Reset
REQ-015 On reset: state=IDLE, cx=0, cy=0, latched layer=0, last_grant=clear, fb_we=0, fb_x=0, fb_y=0, fb_layer=0, fb_data=0, clear_busy=0, clear_done=0.
REQ-016 Reset during CLEAR SHALL abort the sequence with no clear_done pulse; draw_ack SHALL be 0 while reset=1.

Configuration
REQ-017 Macro LAYER_FB_LOCK_EN:
- When defined, a draw request whose draw_layer equals the latched clear layer while in CLEAR SHALL be ineligible (no draw_ack) until the clear completes.
- When undefined, draw eligibility SHALL ignore the layer (REQ-006 only).

Verification (H_PIXELS=4, V_PIXELS=3)
REQ-018 Reset, then draw_req=1 at (2,1,layer 3,color 0x5A) -> draw_ack same cycle; next cycle fb_we=1, fb_x=2, fb_y=1, fb_layer=3, fb_data=0x5A.
REQ-019 clear_start with clear_layer=5, no draws -> 12 consecutive fb_we cycles, (0,0)..(3,2) row-major, data 0, layer 5; clear_done pulses with the 12th write; clear_busy then 0.
REQ-020 Clear of layer 1 with draw_req held on layer 2 (lock undefined) -> grants alternate draw, clear, draw, ...; clear finishes in 24 cycles; draw_ack every other cycle.
REQ-021 LAYER_FB_LOCK_EN defined, clear of layer 2 with draw_req on layer 2 -> no draw_ack until clear_done; first draw write lands after the 12th clear write.
REQ-022 clear_start again mid-clear -> ignored, still exactly 12 writes; reset asserted after the 5th clear write -> fb_we=0, clear_busy=0, no clear_done.
